// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control/execute block.
package alu_pkg;

   // ALUOp codes from the main control unit
   localparam logic [1:0] ALUOP_LS  = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_MUL = 2'b11;

   // ALU control codes
   localparam logic [3:0] ALUC_AND = 4'b0000;
   localparam logic [3:0] ALUC_OR  = 4'b0001;
   localparam logic [3:0] ALUC_ADD = 4'b0010;
   localparam logic [3:0] ALUC_SLT = 4'b0011;
   localparam logic [3:0] ALUC_MUL = 4'b0100;
   localparam logic [3:0] ALUC_XOR = 4'b0101;
   localparam logic [3:0] ALUC_SLL = 4'b0110;
   localparam logic [3:0] ALUC_SUB = 4'b1010;
   localparam logic [3:0] ALUC_ILL = 4'b1111;

   // R-format function codes
   localparam logic [3:0] FUNCT_AND = 4'b0000;
   localparam logic [3:0] FUNCT_OR  = 4'b0001;
   localparam logic [3:0] FUNCT_ADD = 4'b0010;
   localparam logic [3:0] FUNCT_SUB = 4'b0011;
   localparam logic [3:0] FUNCT_SLT = 4'b0100;
   localparam logic [3:0] FUNCT_XOR = 4'b0110;
   localparam logic [3:0] FUNCT_SLL = 4'b0111;

   // Opcode selecting MUL when ALUOp=11
   localparam logic [3:0] OPC_MUL = 4'b0110;

   // Execution FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

   // Decoded operation payload
   typedef struct packed {
      logic [3:0] alu_ctrl;
      logic       illegal;
      logic       is_mul;
   } dec_t;

endpackage

// File: rtl/alu_exec_ctrl_decode.sv
// Combinational ALU-control decoder: {alu_op, funct, opcode} -> control code.
module alu_ctrl_decode
   import alu_pkg::*;
#(
   parameter bit MUL_EN = 1'b1
) (
   input  logic [1:0] alu_op,
   input  logic [3:0] funct,
   input  logic [3:0] opcode,
   output logic [3:0] alu_ctrl,
   output logic       illegal,
   output logic       is_mul
);

   // Full decode; anything not listed falls through to the illegal code
   always_comb begin
      alu_ctrl = ALUC_ILL;
      case (alu_op)
         ALUOP_LS: alu_ctrl = ALUC_ADD;
         ALUOP_BR: alu_ctrl = ALUC_SUB;
         ALUOP_R: begin
            case (funct)
               FUNCT_AND: alu_ctrl = ALUC_AND;
               FUNCT_OR:  alu_ctrl = ALUC_OR;
               FUNCT_ADD: alu_ctrl = ALUC_ADD;
               FUNCT_SUB: alu_ctrl = ALUC_SUB;
               FUNCT_SLT: alu_ctrl = ALUC_SLT;
               FUNCT_XOR: alu_ctrl = ALUC_XOR;
               FUNCT_SLL: alu_ctrl = ALUC_SLL;
               default:   alu_ctrl = ALUC_ILL;
            endcase
         end
         ALUOP_MUL: begin
            if (MUL_EN && (opcode == OPC_MUL)) alu_ctrl = ALUC_MUL;
         end
         default: alu_ctrl = ALUC_ILL;
      endcase
   end

   assign illegal = (alu_ctrl == ALUC_ILL);
   assign is_mul  = (alu_ctrl == ALUC_MUL);

endmodule

// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU: decode, single-cycle ops and iterative shift-add MUL behind valid/ready.
module alu_exec_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [3:0]       funct,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic [3:0]       alu_ctrl,
   output logic             illegal
);

   localparam int unsigned SH_W = $clog2(WIDTH);

   state_e             state_q, state_d;
   dec_t               dec;
   logic               accept;
   logic [WIDTH-1:0]   alu_res;

   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic               zero_q, zero_d;
   logic [3:0]         ctrl_q, ctrl_d;
   logic               ill_q, ill_d;

   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [SH_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]     addend;
   logic [WIDTH:0]     step_sum;
   logic [2*WIDTH-1:0] step_prod;
   logic               mul_last;

   alu_ctrl_decode #(.MUL_EN(MUL_EN)) u_decode (
      .alu_op   (alu_op),
      .funct    (funct),
      .opcode   (opcode),
      .alu_ctrl (dec.alu_ctrl),
      .illegal  (dec.illegal),
      .is_mul   (dec.is_mul)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = dec.is_mul ? ST_MUL : ST_HOLD;
         ST_MUL:  if (mul_last) state_d = ST_HOLD;
         ST_HOLD: begin
            if (out_ready) begin
               if (in_valid) state_d = dec.is_mul ? ST_MUL : ST_HOLD;
               else          state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake strobes
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_HOLD: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: in_ready = 1'b0;
      endcase
   end

   assign accept   = in_valid & in_ready;
   assign mul_last = (state_q == ST_MUL) && (cnt_q == SH_W'(WIDTH - 1));

   // Single-cycle ALU on the live operands, captured only on accept
   always_comb begin
      alu_res = '0;
      case (dec.alu_ctrl)
         ALUC_AND: alu_res = op_a & op_b;
         ALUC_OR:  alu_res = op_a | op_b;
         ALUC_ADD: alu_res = op_a + op_b;
         ALUC_SUB: alu_res = op_a - op_b;
         ALUC_SLT: alu_res = WIDTH'($signed(op_a) < $signed(op_b));
         ALUC_XOR: alu_res = op_a ^ op_b;
         ALUC_SLL: alu_res = op_a << op_b[SH_W-1:0];
         default:  alu_res = '0;
      endcase
   end

   // One shift-add step: upper half accumulates, lower half holds remaining multiplier bits
   assign addend    = prod_q[0] ? {1'b0, mcand_q} : '0;
   assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + addend;
   assign step_prod = {step_sum, prod_q[WIDTH-1:1]};

   // Datapath next-state: capture on accept, iterate in MUL, freeze otherwise
   always_comb begin
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      zero_d   = zero_q;
      ctrl_d   = ctrl_q;
      ill_d    = ill_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      if (accept) begin
         ctrl_d = dec.alu_ctrl;
         ill_d  = dec.illegal;
         if (dec.is_mul) begin
            mcand_d = op_a;
            prod_d  = {WIDTH'(0), op_b};
            cnt_d   = '0;
         end else begin
            res_lo_d = alu_res;
            res_hi_d = '0;
            zero_d   = (alu_res == '0);
         end
      end else if (state_q == ST_MUL) begin
         prod_d = step_prod;
         cnt_d  = cnt_q + SH_W'(1);
         if (mul_last) begin
            res_lo_d = step_prod[WIDTH-1:0];
            res_hi_d = step_prod[2*WIDTH-1:WIDTH];
            zero_d   = (step_prod[WIDTH-1:0] == '0);
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_lo_q <= '0;
         res_hi_q <= '0;
         zero_q   <= 1'b0;
         ctrl_q   <= 4'b0000;
         ill_q    <= 1'b0;
         mcand_q  <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         zero_q   <= zero_d;
         ctrl_q   <= ctrl_d;
         ill_q    <= ill_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
      end
   end

   assign result    = res_lo_q;
   assign result_hi = res_hi_q;
   assign zero      = zero_q;
   assign alu_ctrl  = ctrl_q;
   assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomised + directed bench for alu_exec_ctrl (WIDTH=16, MUL_EN=1).
module tb_alu_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [1:0]  alu_op;
   logic [3:0]  funct, opcode, alu_ctrl;
   logic [15:0] op_a, op_b, result, result_hi;
   logic        zero, illegal;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] lo;
      logic [15:0] hi;
      logic        z;
      logic [3:0]  c;
      logic        ill;
      logic        mul;
   } exp_t;

   alu_exec_ctrl #(.WIDTH(16), .MUL_EN(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .funct     (funct),
      .opcode    (opcode),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .zero      (zero),
      .alu_ctrl  (alu_ctrl),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model straight from the operation table
   function automatic exp_t model(input logic [1:0] op, input logic [3:0] fn, input logic [3:0] oc,
                                  input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      logic [31:0] p;
      int sa, sb;
      e.lo = 16'h0; e.hi = 16'h0; e.c = 4'hF; e.ill = 1'b1; e.mul = 1'b0;
      sa = int'($signed(a)); sb = int'($signed(b));
      case (op)
         2'd0: begin e.c = 4'h2; e.lo = 16'((32'(a) + 32'(b)) % 65536); end
         2'd1: begin e.c = 4'hA; e.lo = 16'((32'(a) + 32'h10000 - 32'(b)) % 65536); end
         2'd2: begin
            case (fn)
               4'd0: begin e.c = 4'h0; e.lo = a & b; end
               4'd1: begin e.c = 4'h1; e.lo = a | b; end
               4'd2: begin e.c = 4'h2; e.lo = 16'((32'(a) + 32'(b)) % 65536); end
               4'd3: begin e.c = 4'hA; e.lo = 16'((32'(a) + 32'h10000 - 32'(b)) % 65536); end
               4'd4: begin e.c = 4'h3; e.lo = (sa < sb) ? 16'd1 : 16'd0; end
               4'd6: begin e.c = 4'h5; e.lo = a ^ b; end
               4'd7: begin e.c = 4'h6; e.lo = 16'((32'(a) * (32'd1 << b[3:0])) % 65536); end
               default: e.c = 4'hF;
            endcase
         end
         default: begin
            if (oc == 4'h6) begin
               e.c = 4'h4; e.mul = 1'b1;
               p = 32'(a) * 32'(b);
               e.lo = p[15:0]; e.hi = p[31:16];
            end
         end
      endcase
      e.ill = (e.c == 4'hF);
      e.z = (e.lo == 16'h0);
      return e;
   endfunction

   task automatic chk_out(input string tag, input exp_t e);
      chk({tag, ".result"},    32'(result),    32'(e.lo));
      chk({tag, ".result_hi"}, 32'(result_hi), 32'(e.hi));
      chk({tag, ".zero"},      32'(zero),      32'(e.z));
      chk({tag, ".alu_ctrl"},  32'(alu_ctrl),  32'(e.c));
      chk({tag, ".illegal"},   32'(illegal),   32'(e.ill));
   endtask

   // Issue one op from IDLE, check latency/results, stall `hold` cycles, optionally consume
   task automatic do_op(input string tag, input logic [1:0] op, input logic [3:0] fn, input logic [3:0] oc,
                        input logic [15:0] a, input logic [15:0] b, input int hold, input bit consume);
      exp_t e;
      int n;
      e = model(op, fn, oc, a, b);
      alu_op = op; funct = fn; opcode = oc; op_a = a; op_b = b;
      in_valid = 1'b1; out_ready = 1'b0;
      #1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      // scramble inputs: must not affect the captured op
      alu_op = 2'($urandom); funct = 4'($urandom); opcode = 4'($urandom);
      op_a = 16'($urandom); op_b = 16'($urandom);
      n = 1;
      while (!out_valid && n < 40) begin
         chk({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ".latency"}, 32'(n), e.mul ? 32'd17 : 32'd1);
      chk_out(tag, e);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
         chk({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
         chk({tag, ".stall_result"}, 32'(result), 32'(e.lo));
         chk({tag, ".stall_ctrl"}, 32'(alu_ctrl), 32'(e.c));
      end
      if (consume) begin
         out_ready = 1'b1;
         #1;
         chk({tag, ".consume_ready"}, 32'(in_ready), 32'd1);
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk({tag, ".drained"}, 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      exp_t e;
      logic [1:0] rop;
      logic [3:0] rfn, roc;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_op = '0; funct = '0; opcode = '0; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.result",    32'(result),    32'd0);
      chk("rst.result_hi", 32'(result_hi), 32'd0);
      chk("rst.zero",      32'(zero),      32'd0);
      chk("rst.alu_ctrl",  32'(alu_ctrl),  32'd0);
      chk("rst.illegal",   32'(illegal),   32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd1);

      // Directed corner cases
      do_op("add_ovf", 2'b10, 4'b0010, 4'h0, 16'h7FFF, 16'h0001, 0, 1'b1);
      do_op("beq",     2'b01, 4'h0,    4'h0, 16'h0005, 16'h0005, 0, 1'b1);
      do_op("slt_neg", 2'b10, 4'b0100, 4'h0, 16'hFFFF, 16'h0001, 0, 1'b1);
      do_op("mul",     2'b11, 4'h0,    4'h6, 16'h0123, 16'h0100, 0, 1'b1);
      do_op("ill_fn",  2'b10, 4'b1111, 4'h0, 16'h1234, 16'h5678, 0, 1'b1);
      do_op("ill_opc", 2'b11, 4'h0,    4'h0, 16'h1234, 16'h5678, 0, 1'b1);
      do_op("sll_max", 2'b10, 4'b0111, 4'h0, 16'h0001, 16'hFFFF, 0, 1'b1);
      do_op("mul_max", 2'b11, 4'h0,    4'h6, 16'hFFFF, 16'hFFFF, 0, 1'b1);

      // Backpressure then back-to-back accept on the consume edge
      do_op("bp", 2'b00, 4'h0, 4'h0, 16'h1111, 16'h2222, 3, 1'b0);
      alu_op = 2'b10; funct = 4'b0110; op_a = 16'hF0F0; op_b = 16'h0FF0;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("b2b.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b.out_valid", 32'(out_valid), 32'd1);
      e = model(2'b10, 4'b0110, 4'h0, 16'hF0F0, 16'h0FF0);
      chk_out("b2b", e);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("b2b.drained", 32'(out_valid), 32'd0);

      // Reset in the middle of a multiply
      alu_op = 2'b11; opcode = 4'h6; op_a = 16'h00FF; op_b = 16'h00FF;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst.out_valid", 32'(out_valid), 32'd0);
      chk("mrst.result",    32'(result),    32'd0);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("mrst.no_valid", 32'(out_valid), 32'd0);
      end
      chk("mrst.in_ready", 32'(in_ready), 32'd1);

      // Random traffic
      for (int i = 0; i < 150; i++) begin
         rop = 2'($urandom_range(0, 3));
         rfn = 4'($urandom_range(0, 15));
         roc = ($urandom_range(0, 1) == 1) ? 4'h6 : 4'($urandom_range(0, 15));
         do_op("rnd", rop, rfn, roc, 16'($urandom), 16'($urandom),
               int'($urandom_range(0, 2)), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
